// File: rtl/regfile_mac_initiator.sv
// regfile_mac_initiator
//
// Neuron-evaluation sequencer that drives a 64x32 three-read/one-write
// register file. One accepted start computes
//   dst = bias + sum_{i=0..len-1} A[aBase+i] * B[bBase+i]
// using wrapping 32-bit two's-complement arithmetic. If reluEn is set, a
// negative result is clamped to 0 before it is written back.
//
// Sequence: IDLE -> BIAS (1 cycle) -> MAC (len cycles) -> WRITE (1 cycle) -> IDLE.
// done pulses in the cycle after WRITE.
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start                   command strobe, taken only in IDLE
//   len, aBase, bBase       term count and operand vector base addresses
//   biasAddr, dstAddr       bias source and result destination addresses
//   reluEn                  clamp negative result to zero
//   busy, done              status: busy from BIAS through WRITE, done one cycle after WRITE
//   writeEnable/wrAddr/wrData   register file write port
//   rdAddrA/B/C, rdDataA/B/C    register file read ports (combinational reads)
module regfile_mac_initiator #(
  parameter int NUM_ADDR_BITS = 6,
  parameter int REG_WIDTH     = 32,
  parameter int LEN_BITS      = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_BITS-1:0]      len,
  input  logic [NUM_ADDR_BITS-1:0] aBase,
  input  logic [NUM_ADDR_BITS-1:0] bBase,
  input  logic [NUM_ADDR_BITS-1:0] biasAddr,
  input  logic [NUM_ADDR_BITS-1:0] dstAddr,
  input  logic                     reluEn,
  output logic                     busy,
  output logic                     done,
  output logic                     writeEnable,
  output logic [NUM_ADDR_BITS-1:0] wrAddr,
  output logic [REG_WIDTH-1:0]     wrData,
  output logic [NUM_ADDR_BITS-1:0] rdAddrA,
  output logic [NUM_ADDR_BITS-1:0] rdAddrB,
  output logic [NUM_ADDR_BITS-1:0] rdAddrC,
  input  logic [REG_WIDTH-1:0]     rdDataA,
  input  logic [REG_WIDTH-1:0]     rdDataB,
  input  logic [REG_WIDTH-1:0]     rdDataC
);

  typedef enum logic [1:0] {IDLE, BIAS, MAC, WRITE} stateT;

  stateT                    stateReg, stateNext;
  logic [LEN_BITS-1:0]      lenReg, lenNext;
  logic [LEN_BITS-1:0]      idxReg, idxNext;
  logic [NUM_ADDR_BITS-1:0] dstAddrReg, dstAddrNext;
  logic                     reluEnReg, reluEnNext;
  logic [REG_WIDTH-1:0]     accReg, accNext;
  logic                     busyReg, busyNext;
  logic                     doneReg, doneNext;
  logic                     writeEnableReg, writeEnableNext;
  logic [NUM_ADDR_BITS-1:0] wrAddrReg, wrAddrNext;
  logic [REG_WIDTH-1:0]     wrDataReg, wrDataNext;
  logic [NUM_ADDR_BITS-1:0] rdAddrAReg, rdAddrANext;
  logic [NUM_ADDR_BITS-1:0] rdAddrBReg, rdAddrBNext;
  logic [NUM_ADDR_BITS-1:0] rdAddrCReg, rdAddrCNext;

  // Low REG_WIDTH bits of the product; higher bits are discarded on purpose.
  logic [REG_WIDTH-1:0] product;
  logic [REG_WIDTH-1:0] macSum;
  logic [REG_WIDTH-1:0] writeSource;
  logic [REG_WIDTH-1:0] writeValue;
  logic                 lastTerm;

  assign product  = rdDataA * rdDataB;
  assign macSum   = accReg + product;
  assign lastTerm = (idxReg == lenReg - LEN_BITS'(1));

  // The write data is registered on the edge that enters WRITE. It is taken
  // from the value the accumulator is about to hold, so it is never stale by
  // one term. In BIAS that value is the bias itself (len == 0 case).
  assign writeSource = (stateReg == BIAS) ? rdDataC : macSum;
  assign writeValue  = (reluEnReg && writeSource[REG_WIDTH-1]) ? '0 : writeSource;

  always_comb begin
    stateNext       = stateReg;
    lenNext         = lenReg;
    idxNext         = idxReg;
    dstAddrNext     = dstAddrReg;
    reluEnNext      = reluEnReg;
    accNext         = accReg;
    busyNext        = busyReg;
    doneNext        = 1'b0;
    writeEnableNext = 1'b0;
    wrAddrNext      = wrAddrReg;
    wrDataNext      = wrDataReg;
    rdAddrANext     = rdAddrAReg;
    rdAddrBNext     = rdAddrBReg;
    rdAddrCNext     = rdAddrCReg;

    case (stateReg)
      IDLE: begin
        if (start) begin
          // Read addresses are loaded here so they are already valid
          // (registered) in the BIAS cycle and in the first MAC cycle.
          stateNext   = BIAS;
          lenNext     = len;
          idxNext     = '0;
          dstAddrNext = dstAddr;
          reluEnNext  = reluEn;
          rdAddrANext = aBase;
          rdAddrBNext = bBase;
          rdAddrCNext = biasAddr;
          busyNext    = 1'b1;
        end
      end
      BIAS: begin
        accNext = rdDataC;
        if (lenReg == '0) begin
          stateNext       = WRITE;
          writeEnableNext = 1'b1;
          wrAddrNext      = dstAddrReg;
          wrDataNext      = writeValue;
        end else begin
          stateNext = MAC;
        end
      end
      MAC: begin
        accNext = macSum;
        if (lastTerm) begin
          stateNext       = WRITE;
          writeEnableNext = 1'b1;
          wrAddrNext      = dstAddrReg;
          wrDataNext      = writeValue;
        end else begin
          idxNext     = idxReg + LEN_BITS'(1);
          // Natural NUM_ADDR_BITS overflow gives the 63 -> 0 wrap.
          rdAddrANext = rdAddrAReg + NUM_ADDR_BITS'(1);
          rdAddrBNext = rdAddrBReg + NUM_ADDR_BITS'(1);
        end
      end
      WRITE: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
        doneNext  = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg       <= IDLE;
      lenReg         <= '0;
      idxReg         <= '0;
      dstAddrReg     <= '0;
      reluEnReg      <= 1'b0;
      accReg         <= '0;
      busyReg        <= 1'b0;
      doneReg        <= 1'b0;
      writeEnableReg <= 1'b0;
      wrAddrReg      <= '0;
      wrDataReg      <= '0;
      rdAddrAReg     <= '0;
      rdAddrBReg     <= '0;
      rdAddrCReg     <= '0;
    end else begin
      stateReg       <= stateNext;
      lenReg         <= lenNext;
      idxReg         <= idxNext;
      dstAddrReg     <= dstAddrNext;
      reluEnReg      <= reluEnNext;
      accReg         <= accNext;
      busyReg        <= busyNext;
      doneReg        <= doneNext;
      writeEnableReg <= writeEnableNext;
      wrAddrReg      <= wrAddrNext;
      wrDataReg      <= wrDataNext;
      rdAddrAReg     <= rdAddrANext;
      rdAddrBReg     <= rdAddrBNext;
      rdAddrCReg     <= rdAddrCNext;
    end
  end

  assign busy        = busyReg;
  assign done        = doneReg;
  assign writeEnable = writeEnableReg;
  assign wrAddr      = wrAddrReg;
  assign wrData      = wrDataReg;
  assign rdAddrA     = rdAddrAReg;
  assign rdAddrB     = rdAddrBReg;
  assign rdAddrC     = rdAddrCReg;

endmodule

// File: tb/tb_regfile_mac_initiator.sv
// Directed bench for regfile_mac_initiator. A behavioural 64x32 register
// file with combinational reads sits on the DUT ports. Outputs are sampled
// on the falling clock edge, and inputs are driven there too.
module tb_regfile_mac_initiator;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  len;
  logic [5:0]  aBase, bBase, biasAddr, dstAddr;
  logic        reluEn;
  logic        busy, done, writeEnable;
  logic [5:0]  wrAddr, rdAddrA, rdAddrB, rdAddrC;
  logic [31:0] wrData, rdDataA, rdDataB, rdDataC;

  logic [31:0] rf [64];
  logic        pokeEn;
  logic [5:0]  pokeAddr;
  logic [31:0] pokeData;
  int          wrCount;
  int          doneCount;

  int checks;
  int errors;
  logic [5:0] addrLog [128];

  regfile_mac_initiator dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .aBase(aBase), .bBase(bBase), .biasAddr(biasAddr), .dstAddr(dstAddr),
    .reluEn(reluEn), .busy(busy), .done(done), .writeEnable(writeEnable),
    .wrAddr(wrAddr), .wrData(wrData),
    .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .rdAddrC(rdAddrC),
    .rdDataA(rdDataA), .rdDataB(rdDataB), .rdDataC(rdDataC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdDataA = rf[rdAddrA];
  assign rdDataB = rf[rdAddrB];
  assign rdDataC = rf[rdAddrC];

  initial begin
    wrCount   = 0;
    doneCount = 0;
  end

  always @(posedge clk) begin
    if (writeEnable) begin
      rf[wrAddr] <= wrData;
      wrCount    <= wrCount + 1;
    end else if (pokeEn) begin
      rf[pokeAddr] <= pokeData;
    end
    if (done) doneCount <= doneCount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [5:0] a, input logic [31:0] d);
    pokeEn   = 1'b1;
    pokeAddr = a;
    pokeData = d;
    @(negedge clk);
    pokeEn   = 1'b0;
  endtask

  // Issues one command and waits (bounded) for done. cyc is the number of
  // falling edges from driving start until done is observed.
  task automatic runCmd(input logic [6:0] l, input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] bi, input logic [5:0] d, input logic r,
                        input bit extraStart, output int cyc);
    int wrBefore;
    bit seen;
    wrBefore = wrCount;
    seen     = 1'b0;
    len = l; aBase = a; bBase = b; biasAddr = bi; dstAddr = d; reluEn = r;
    start = 1'b1;
    cyc = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check("busyAfterStart", 32'(busy), 32'd1);
        check("rdAddrCInBias", 32'(rdAddrC), 32'(bi));
      end
      if (extraStart && cyc == 2) start = 1'b1;
      if (extraStart && cyc == 3) start = 1'b0;
      if (cyc < 128) addrLog[cyc] = rdAddrA;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("doneSeen", 32'(seen), 32'd1);
    check("latency", 32'(cyc), 32'(l) + 32'd3);
    check("busyInDoneCycle", 32'(busy), 32'd0);
    check("oneWritePerCmd", 32'(wrCount - wrBefore), 32'd1);
  endtask

  initial begin
    int cyc;
    int wrSnap;
    int doneSnap;
    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0; len = '0; aBase = '0; bBase = '0;
    biasAddr = '0; dstAddr = '0; reluEn = 1'b0;
    pokeEn = 1'b0; pokeAddr = '0; pokeData = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstDone", 32'(done), 32'd0);
    check("rstWe", 32'(writeEnable), 32'd0);
    check("rstWrAddr", 32'(wrAddr), 32'd0);
    check("rstWrData", wrData, 32'd0);
    check("rstRdAddrA", 32'(rdAddrA), 32'd0);
    check("rstRdAddrB", 32'(rdAddrB), 32'd0);
    check("rstRdAddrC", 32'(rdAddrC), 32'd0);
    reset = 1'b0;

    // Basic dot product: 5 + 1*4 + 2*5 + 3*6 = 37
    poke(6'd10, 32'd5);
    poke(6'd1, 32'd1); poke(6'd2, 32'd2); poke(6'd3, 32'd3);
    poke(6'd4, 32'd4); poke(6'd5, 32'd5); poke(6'd6, 32'd6);
    runCmd(7'd3, 6'd1, 6'd4, 6'd10, 6'd20, 1'b0, 1'b0, cyc);
    check("basicR20", rf[20], 32'h25);
    check("basicAddrA0", 32'(addrLog[2]), 32'd1);
    check("basicAddrA2", 32'(addrLog[4]), 32'd3);
    $display("txn basic: len=3 R20=%0h cycles=%0d", rf[20], cyc);

    // len = 0 with negative bias, with and without ReLU
    poke(6'd10, 32'hFFFF_FFF0);
    runCmd(7'd0, 6'd1, 6'd4, 6'd10, 6'd21, 1'b1, 1'b0, cyc);
    check("len0ReluR21", rf[21], 32'd0);
    $display("txn len0 relu: R21=%0h cycles=%0d", rf[21], cyc);
    runCmd(7'd0, 6'd1, 6'd4, 6'd10, 6'd21, 1'b0, 1'b0, cyc);
    check("len0NoReluR21", rf[21], 32'hFFFF_FFF0);
    $display("txn len0 norelu: R21=%0h cycles=%0d", rf[21], cyc);

    // Address wrap 0x3E,0x3F,0x00,0x01; all ones -> 1 + 4 = 5
    poke(6'd62, 32'd1); poke(6'd63, 32'd1); poke(6'd0, 32'd1); poke(6'd1, 32'd1);
    poke(6'd8, 32'd1); poke(6'd9, 32'd1); poke(6'd10, 32'd1); poke(6'd11, 32'd1);
    poke(6'd12, 32'd1);
    runCmd(7'd4, 6'h3E, 6'd8, 6'd12, 6'd30, 1'b0, 1'b0, cyc);
    check("wrapAddr0", 32'(addrLog[2]), 32'h3E);
    check("wrapAddr1", 32'(addrLog[3]), 32'h3F);
    check("wrapAddr2", 32'(addrLog[4]), 32'h00);
    check("wrapAddr3", 32'(addrLog[5]), 32'h01);
    check("wrapR30", rf[30], 32'd5);
    $display("txn wrap: R30=%0h cycles=%0d", rf[30], cyc);

    // Overflow: product low bits and accumulator wrap
    poke(6'd2, 32'h0001_0000); poke(6'd3, 32'h0001_0000); poke(6'd13, 32'd0);
    runCmd(7'd1, 6'd2, 6'd3, 6'd13, 6'd31, 1'b0, 1'b0, cyc);
    check("ovfProdR31", rf[31], 32'd0);
    $display("txn ovf1: R31=%0h", rf[31]);
    poke(6'd2, 32'hFFFF_FFFF); poke(6'd3, 32'd2); poke(6'd13, 32'd3);
    runCmd(7'd1, 6'd2, 6'd3, 6'd13, 6'd31, 1'b0, 1'b0, cyc);
    check("ovfAccR31", rf[31], 32'd1);
    $display("txn ovf2: R31=%0h", rf[31]);

    // dst aliases A source; a second start while busy is ignored
    poke(6'd1, 32'd7); poke(6'd4, 32'd3); poke(6'd13, 32'd0);
    runCmd(7'd1, 6'd1, 6'd4, 6'd13, 6'd1, 1'b0, 1'b1, cyc);
    check("aliasR1", rf[1], 32'd21);
    wrSnap = wrCount;
    repeat (6) @(negedge clk);
    check("ignoredStartNoWrite", 32'(wrCount), 32'(wrSnap));
    check("ignoredStartIdle", 32'(busy), 32'd0);
    $display("txn alias: R1=%0h cycles=%0d", rf[1], cyc);

    // Reset during MAC term 2 of a len=5 command
    poke(6'd1, 32'd1); poke(6'd2, 32'd2); poke(6'd3, 32'd3);
    poke(6'd4, 32'd4); poke(6'd5, 32'd5); poke(6'd6, 32'd6);
    poke(6'd7, 32'd7); poke(6'd8, 32'd8); poke(6'd9, 32'd9);
    poke(6'd10, 32'd5);
    wrSnap   = wrCount;
    doneSnap = doneCount;
    len = 7'd5; aBase = 6'd1; bBase = 6'd4; biasAddr = 6'd10; dstAddr = 6'd20; reluEn = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;   // BIAS
    @(negedge clk);                 // MAC term 0
    @(negedge clk);                 // MAC term 1
    @(negedge clk);                 // MAC term 2
    check("midCmdBusy", 32'(busy), 32'd1);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("midRstBusy", 32'(busy), 32'd0);
    check("midRstDone", 32'(done), 32'd0);
    check("midRstWe", 32'(writeEnable), 32'd0);
    check("midRstRdAddrA", 32'(rdAddrA), 32'd0);
    check("midRstWrData", wrData, 32'd0);
    repeat (8) @(negedge clk);
    check("midRstStillIdle", 32'(busy), 32'd0);
    check("midRstNoWrite", 32'(wrCount), 32'(wrSnap));
    check("midRstNoDone", 32'(doneCount), 32'(doneSnap));
    check("midRstR20", rf[20], 32'h25);
    $display("txn reset-mid-mac: R20=%0h writes=%0d", rf[20], wrCount - wrSnap);

    // Command after the aborted one completes normally
    runCmd(7'd3, 6'd1, 6'd4, 6'd10, 6'd22, 1'b0, 1'b0, cyc);
    check("afterRstR22", rf[22], 32'h25);
    $display("txn after-reset: R22=%0h cycles=%0d", rf[22], cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
